hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard unit for the pipelined core, replacing the fixed two-operand, single-cycle-load hazard logic. It resolves E-stage forwarding for NSRC source operands. It tracks outstanding variable-latency loads in a per-register pending scoreboard and stalls D on RAW/WAW hits or when the outstanding-load limit is reached. It also generates the F/D/E stall and flush controls.

## Interface
Parameters:
- REG_W, 4, register index width; the scoreboard covers 2^REG_W registers
- NSRC, 3, source operands per instruction (D and E)
- MAX_OUT, 4, maximum outstanding loads (1..15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- SrcD  in  NSRC*REG_W  D-stage source register indices; operand i is at bits [i*REG_W +: REG_W]
- SrcValidD  in  NSRC  per-operand valid, D stage
- DstD  in  REG_W  D-stage destination register
- RegWriteD  in  1  D-stage instruction writes DstD
- MemtoRegD  in  1  D-stage instruction is a load
- SrcE  in  NSRC*REG_W  E-stage source register indices
- SrcValidE  in  NSRC  per-operand valid, E stage
- DstE  in  REG_W  E-stage destination
- MemtoRegE  in  1  E-stage instruction is a valid load; issues to memory this cycle
- DstM, DstW  in  REG_W  M/W destinations
- RegWriteM, RegWriteW  in  1  M/W write enables
- MemRespValid  in  1  load response completes this cycle
- MemRespDst  in  REG_W  destination of the completing load
- BranchTakenE, PCWrPendingF, PCSrcW  in  1  control-hazard sources
- ForwardE  out  NSRC*2  per-operand mux select: 10 = M, 01 = W, 00 = register file
- StallF, StallD, FlushD, FlushE  out  1  pipeline controls
- OutCount  out  4  outstanding loads
- RespErr  out  1  sticky protocol-error flag
- StallCount  out  32  D-stall cycle counter (see Configuration)

## Operation
- Forwarding, per operand i, purely combinational:
  - ForwardE[i] = 10 if SrcValidE[i] & RegWriteM & SrcE[i]==DstM.
  - Else 01 if SrcValidE[i] & RegWriteW & SrcE[i]==DstW.
  - Else 00.
  - M has priority over W.
- Pending vector P[2^REG_W], registered:
  - Set P[DstE] on an edge where MemtoRegE=1.
  - Clear P[MemRespDst] on an edge where MemRespValid=1.
  - If the same register is set and cleared on one edge, set wins (a new load supersedes the old one).
- OutCount, registered:
  - +1 on issue, −1 on response, unchanged when both occur.
  - Never exceeds MAX_OUT, because issue is prevented by the stall.
- RespErr, sticky until reset. It sets on either of:
  - MemRespValid while P[MemRespDst]=0 (P is unchanged).
  - MemRespValid while OutCount=0 and no issue this cycle (OutCount holds at 0).
- ldStall, combinational, is the OR of:
  - Load-use: MemtoRegE & any valid SrcD[i]==DstE.
  - RAW pending: any valid SrcD[i] with P[SrcD[i]]=1.
  - WAW pending: RegWriteD & P[DstD]=1.
  - Full: MemtoRegD & OutCount==MAX_OUT & no response this cycle.
- Control outputs:
  - StallD = ldStall.
  - StallF = ldStall | PCWrPendingF.
  - FlushE = ldStall | BranchTakenE.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
- The D-stall conditions read registered P and OutCount only. A response clears its register's stall from the next cycle.

## Timing
- Reset values: P=0, OutCount=0, RespErr=0, StallCount=0.
- Combinational outputs reflect their inputs during reset; with no hazards they are all 0 / 00.
- Reset mid-operation clears all state immediately. Responses still in flight after reset are flagged as RespErr.
- Load issued at edge t (MemtoRegE high in cycle t−1): P is visible from cycle t.
- Response in cycle r: a dependent instruction stalls through cycle r and proceeds in cycle r+1.
- Forwarding has zero latency.
- No combinational path from MemRespValid to StallD except through the full condition.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCount increments on each edge with StallD=1.
  - It saturates at 0xFFFFFFFF.
  - It is cleared by reset.
- Not defined: StallCount is tied to 0 and no counter flops are synthesised.

## Test plan
- Forwarding priority: SrcE[0]=3, DstM=3, DstW=3, both RegWrite=1 -> ForwardE[0]=10. With RegWriteM=0 -> 01. SrcValidE[0]=0 -> 00.
- Load-use: MemtoRegE=1, DstE=5, SrcD[1]=5 valid -> StallD=StallF=FlushE=1 for one cycle. The next cycle stalls on P[5] until a response with MemRespDst=5. The cycle after the response, StallD=0.
- Full: issue 4 loads to r1..r4 (MAX_OUT=4) -> OutCount=4. MemtoRegD=1 -> StallD=1. MemRespValid in the same cycle -> StallD=0 and OutCount stays 4.
- Set/clear collision: P[7]=1, response for r7 and new load to r7 on the same edge -> P[7]=1, OutCount unchanged.
- Spurious response: MemRespValid, MemRespDst=9, P[9]=0 -> RespErr=1 and stays 1 until reset. Async reset mid-cycle -> P=0, OutCount=0, RespErr=0 immediately.
- Control: BranchTakenE=1 -> FlushD=FlushE=1, StallF=0. PCWrPendingF=1 -> StallF=FlushD=1. With HAZARD_PERF_CNT_EN, 3 stall cycles -> StallCount=3.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit signal bundle. master = pipeline side, slave = hazard unit.
interface hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int NSRC  = 3
);
  logic [NSRC*REG_W-1:0] SrcD;
  logic [NSRC-1:0]       SrcValidD;
  logic [REG_W-1:0]      DstD;
  logic                  RegWriteD;
  logic                  MemtoRegD;
  logic [NSRC*REG_W-1:0] SrcE;
  logic [NSRC-1:0]       SrcValidE;
  logic [REG_W-1:0]      DstE;
  logic                  MemtoRegE;
  logic [REG_W-1:0]      DstM;
  logic [REG_W-1:0]      DstW;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic                  MemRespValid;
  logic [REG_W-1:0]      MemRespDst;
  logic                  BranchTakenE;
  logic                  PCWrPendingF;
  logic                  PCSrcW;
  logic [NSRC*2-1:0]     ForwardE;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;
  logic [3:0]            OutCount;
  logic                  RespErr;
  logic [31:0]           StallCount;

  modport master (
    output SrcD, SrcValidD, DstD, RegWriteD, MemtoRegD,
           SrcE, SrcValidE, DstE, MemtoRegE,
           DstM, DstW, RegWriteM, RegWriteW,
           MemRespValid, MemRespDst,
           BranchTakenE, PCWrPendingF, PCSrcW,
    input  ForwardE, StallF, StallD, FlushD, FlushE,
           OutCount, RespErr, StallCount
  );

  modport slave (
    input  SrcD, SrcValidD, DstD, RegWriteD, MemtoRegD,
           SrcE, SrcValidE, DstE, MemtoRegE,
           DstM, DstW, RegWriteM, RegWriteW,
           MemRespValid, MemRespDst,
           BranchTakenE, PCWrPendingF, PCSrcW,
    output ForwardE, StallF, StallD, FlushD, FlushE,
           OutCount, RespErr, StallCount
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Forwarding, pending-load scoreboard and stall/flush control for NSRC-operand pipeline.
// Optional D-stall performance counter enabled by defining HAZARD_PERF_CNT_EN.

// One source operand: E-stage forward select and D-stage load hazard detect.
module hazard_scoreboard_lane #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0]       srcD,
  input  logic                   srcValidD,
  input  logic [REG_W-1:0]       srcE,
  input  logic                   srcValidE,
  input  logic [REG_W-1:0]       dstE,
  input  logic                   memtoRegE,
  input  logic [REG_W-1:0]       dstM,
  input  logic                   regWriteM,
  input  logic [REG_W-1:0]       dstW,
  input  logic                   regWriteW,
  input  logic [(1<<REG_W)-1:0]  pend,
  output logic [1:0]             fwd,
  output logic                   hit
);
  always_comb begin
    fwd = 2'b00;
    if (srcValidE && regWriteM && srcE == dstM)      fwd = 2'b10;
    else if (srcValidE && regWriteW && srcE == dstW) fwd = 2'b01;
  end

  assign hit = srcValidD && ((memtoRegE && srcD == dstE) || pend[srcD]);
endmodule

module hazard_scoreboard #(
  parameter int REG_W   = 4,
  parameter int NSRC    = 3,
  parameter int MAX_OUT = 4
) (
  input logic          clk,
  input logic          reset,
  hazard_scoreboard_if.slave hz
);
  localparam int         NREG    = 1 << REG_W;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  logic [NREG-1:0]            pend, pendNext;
  logic [3:0]                 outCount;
  logic                       respErr;
  logic [NSRC-1:0][1:0]       fwd;
  logic [NSRC-1:0]            srcHit;
  logic                       issue, resp, respHit, respDec;
  logic                       wawHit, fullHit, ldStall;

  genvar i;
  generate
    for (i = 0; i < NSRC; i++) begin : g_lane
      hazard_scoreboard_lane #(.REG_W(REG_W)) u_lane (
        .srcD      (hz.SrcD[i*REG_W +: REG_W]),
        .srcValidD (hz.SrcValidD[i]),
        .srcE      (hz.SrcE[i*REG_W +: REG_W]),
        .srcValidE (hz.SrcValidE[i]),
        .dstE      (hz.DstE),
        .memtoRegE (hz.MemtoRegE),
        .dstM      (hz.DstM),
        .regWriteM (hz.RegWriteM),
        .dstW      (hz.DstW),
        .regWriteW (hz.RegWriteW),
        .pend      (pend),
        .fwd       (fwd[i]),
        .hit       (srcHit[i])
      );
    end
  endgenerate

  assign issue   = hz.MemtoRegE;
  assign resp    = hz.MemRespValid;
  assign respHit = pend[hz.MemRespDst];
  // Only a response matching a pending entry retires an outstanding load.
  assign respDec = resp && respHit && (outCount != 4'd0);

  assign wawHit  = hz.RegWriteD && pend[hz.DstD];
  // The sole path from MemRespValid to StallD: a same-cycle response frees a slot.
  assign fullHit = hz.MemtoRegD && (outCount == MAX_CNT) && !resp;
  assign ldStall = (|srcHit) || wawHit || fullHit;

  always_comb begin
    pendNext = pend;
    if (resp)  pendNext[hz.MemRespDst] = 1'b0;
    if (issue) pendNext[hz.DstE]       = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      outCount <= 4'd0;
      respErr  <= 1'b0;
    end else begin
      pend <= pendNext;
      case ({issue, respDec})
        2'b10:   outCount <= outCount + 4'd1;
        2'b01:   outCount <= outCount - 4'd1;
        default: outCount <= outCount;
      endcase
      if (resp && (!respHit || (outCount == 4'd0 && !issue)))
        respErr <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           stallCnt <= 32'd0;
    else if (ldStall && stallCnt != '1)  stallCnt <= stallCnt + 32'd1;
  end
  assign hz.StallCount = stallCnt;
`else
  assign hz.StallCount = 32'd0;
`endif

  assign hz.ForwardE = fwd;
  assign hz.StallD   = ldStall;
  assign hz.StallF   = ldStall || hz.PCWrPendingF;
  assign hz.FlushE   = ldStall || hz.BranchTakenE;
  assign hz.FlushD   = hz.PCWrPendingF || hz.PCSrcW || hz.BranchTakenE;
  assign hz.OutCount = outCount;
  assign hz.RespErr  = respErr;
endmodule
